// File: rtl/tsqr_pkg.sv
// Shared constants and FSM encoding for the TSQR tile feed controller.
package tsqr_pkg;
    localparam int MATRIX_WIDTH = 8;
    localparam int RAM_WIDTH    = 512;
    localparam int CNT_WIDTH    = 16;
    localparam int FIRST_BURST  = 3;
    localparam int E_WIDTH      = 32;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        WAIT_FI,
        WAIT_DONE,
        DONE
    } feed_state_t;
endpackage

// File: rtl/tsqr_row_fifo.sv
// Synchronous row FIFO with occupancy count; push while full is taken
// only when a pop happens in the same cycle.
module tsqr_row_fifo #(
    parameter int WIDTH = 1120,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count
);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < DEPTH_C) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/tsqr_tile_feed_ctrl.sv
// Buffers upstream rows and releases them to the TSQR core as whole tiles:
// an initial burst, then one tile per alternating mem0/mem1 finish.
module tsqr_tile_feed_ctrl
    import tsqr_pkg::*;
#(
    parameter int MATRIX_WIDTH_P = MATRIX_WIDTH,
    parameter int RAM_WIDTH_P    = RAM_WIDTH,
    parameter int CNT_WIDTH_P    = CNT_WIDTH,
    parameter int FIRST_BURST_P  = FIRST_BURST
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tsqr_en,
    input  logic [CNT_WIDTH_P-1:0] tile_no,
    input  logic                   src_valid,
    output logic                   src_ready,
    input  logic [RAM_WIDTH_P-1:0] src_ug,
    input  logic [RAM_WIDTH_P-1:0] src_pg,
    input  logic [31:0]            src_e_ug,
    input  logic [31:0]            src_e_pg,
    input  logic [31:0]            src_e_upg,
    input  logic                   mem0_fi_c_0,
    input  logic                   mem1_fi_c_0,
    input  logic                   tsqr_fi,
    output logic [RAM_WIDTH_P-1:0] ug_i,
    output logic [RAM_WIDTH_P-1:0] pg_i,
    output logic                   ug_ready,
    output logic                   pg_ready,
    output logic [31:0]            e_ug,
    output logic [31:0]            e_pg,
    output logic [31:0]            e_upg,
    output logic                   e_ug_ready,
    output logic                   e_pg_ready,
    output logic                   e_upg_ready,
    output logic                   busy,
    output logic                   tsqr_done,
    output logic                   start_err
);
    localparam int DEPTH = 2 * MATRIX_WIDTH_P;
    localparam int AW    = $clog2(DEPTH);
    localparam int EW    = E_WIDTH;
    localparam int ROWW  = 2 * RAM_WIDTH_P + 3 * EW;
    localparam int RCW   = $clog2(MATRIX_WIDTH_P + 1);

    localparam logic [AW:0]            DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]            MW_C    = (AW + 1)'(MATRIX_WIDTH_P);
    localparam logic [RCW-1:0]         RC_LAST = RCW'(MATRIX_WIDTH_P - 1);
    localparam logic [CNT_WIDTH_P-1:0] BURST_C = CNT_WIDTH_P'(FIRST_BURST_P);

    feed_state_t            state;
    logic [AW:0]            count;
    logic [ROWW-1:0]        din;
    logic [ROWW-1:0]        dout;
    logic                   rdy_q;
    logic                   push;
    logic                   pop;
    logic                   fill_ok;
    logic                   last_row;
    logic                   exp_hit;
    logic                   tile0;
    logic [CNT_WIDTH_P-1:0] tile_q;
    logic [CNT_WIDTH_P-1:0] tiles_sent;
    logic [CNT_WIDTH_P-1:0] sent_nx;
    logic [RCW-1:0]         row_cnt;
    logic                   mem_sel;
    logic                   fi0_q;
    logic                   fi1_q;

    assign src_ready = rdy_q && (count < DEPTH_C);
    assign push      = src_valid && src_ready;
    assign din       = {src_ug, src_pg, src_e_ug, src_e_pg, src_e_upg};
    assign fill_ok   = count >= MW_C;
    assign pop       = (state == FILL && fill_ok) || (state == STREAM);
    assign last_row  = (state == STREAM) && (row_cnt == RC_LAST);
    assign sent_nx   = tiles_sent + 1'b1;
    assign tile0     = tiles_sent == '0;
    // A finish arriving in the waiting cycle itself releases the tile at once.
    assign exp_hit   = mem_sel ? (fi1_q || mem1_fi_c_0)
                               : (fi0_q || mem0_fi_c_0);

    tsqr_row_fifo #(
        .WIDTH (ROWW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rdy_q       <= 1'b0;
            ug_i        <= '0;
            pg_i        <= '0;
            ug_ready    <= 1'b0;
            pg_ready    <= 1'b0;
            e_ug        <= '0;
            e_pg        <= '0;
            e_upg       <= '0;
            e_ug_ready  <= 1'b0;
            e_pg_ready  <= 1'b0;
            e_upg_ready <= 1'b0;
            busy        <= 1'b0;
            tsqr_done   <= 1'b0;
            start_err   <= 1'b0;
            tile_q      <= '0;
            tiles_sent  <= '0;
            row_cnt     <= '0;
            mem_sel     <= 1'b0;
            fi0_q       <= 1'b0;
            fi1_q       <= 1'b0;
        end else begin
            rdy_q       <= 1'b1;
            ug_ready    <= pop;
            pg_ready    <= pop;
            e_ug_ready  <= pop && tile0;
            e_pg_ready  <= pop && tile0;
            e_upg_ready <= pop && tile0;
            tsqr_done   <= 1'b0;
            start_err   <= tsqr_en && (state != IDLE);
            if (pop) begin
                ug_i <= dout[ROWW-1 -: RAM_WIDTH_P];
                pg_i <= dout[ROWW-RAM_WIDTH_P-1 -: RAM_WIDTH_P];
            end
            if (pop && tile0) begin
                e_ug  <= dout[3*EW-1 -: EW];
                e_pg  <= dout[2*EW-1 -: EW];
                e_upg <= dout[EW-1:0];
            end
            // Finishes may land while a tile is streaming; keep them.
            if (state != IDLE) begin
                if (mem0_fi_c_0) fi0_q <= 1'b1;
                if (mem1_fi_c_0) fi1_q <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (tsqr_en) begin
                        fi0_q      <= 1'b0;
                        fi1_q      <= 1'b0;
                        tile_q     <= tile_no;
                        tiles_sent <= '0;
                        row_cnt    <= '0;
                        mem_sel    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= (tile_no == '0) ? DONE : FILL;
                    end
                end
                FILL: begin
                    if (fill_ok) begin
                        row_cnt <= RCW'(1);
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (last_row) begin
                        row_cnt    <= '0;
                        tiles_sent <= sent_nx;
                        if (sent_nx == tile_q) begin
                            state <= WAIT_DONE;
                        end else if (sent_nx < BURST_C) begin
                            state <= FILL;
                        end else begin
                            state <= WAIT_FI;
                        end
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                WAIT_FI: begin
                    if (exp_hit) begin
                        if (mem_sel) fi1_q <= 1'b0;
                        else         fi0_q <= 1'b0;
                        mem_sel <= ~mem_sel;
                        state   <= FILL;
                    end
                end
                WAIT_DONE: begin
                    if (tsqr_fi) begin
                        tsqr_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Zero-tile jobs pulse here; normal jobs pulsed on entry.
                    tsqr_done <= ~tsqr_done;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tsqr_tile_feed_ctrl.sv
// Directed scenarios with random row payloads, checked against an in-order
// row queue plus tile-timing rules computed from cycle stamps.
module tb_tsqr_tile_feed_ctrl;
    localparam int MW = 8;
    localparam int RW = 512;

    typedef struct {
        logic [RW-1:0] ug;
        logic [RW-1:0] pg;
        logic [31:0]   eu;
        logic [31:0]   ep;
        logic [31:0]   eup;
    } row_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tsqr_en = 1'b0;
    logic [15:0]   tile_no = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [RW-1:0] src_ug = '0;
    logic [RW-1:0] src_pg = '0;
    logic [31:0]   src_e_ug = '0;
    logic [31:0]   src_e_pg = '0;
    logic [31:0]   src_e_upg = '0;
    logic          mem0 = 1'b0;
    logic          mem1 = 1'b0;
    logic          fi = 1'b0;
    logic [RW-1:0] ug_i;
    logic [RW-1:0] pg_i;
    logic          ug_ready;
    logic          pg_ready;
    logic [31:0]   e_ug;
    logic [31:0]   e_pg;
    logic [31:0]   e_upg;
    logic          e_ug_ready;
    logic          e_pg_ready;
    logic          e_upg_ready;
    logic          busy;
    logic          tsqr_done;
    logic          start_err;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rows_out = 0;
    int   feed_left = 0;
    int   row_cyc[$];
    row_t exp_q[$];
    row_t cur;
    int   en_cyc;
    int   p_cyc;

    tsqr_tile_feed_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tsqr_en     (tsqr_en),
        .tile_no     (tile_no),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_ug      (src_ug),
        .src_pg      (src_pg),
        .src_e_ug    (src_e_ug),
        .src_e_pg    (src_e_pg),
        .src_e_upg   (src_e_upg),
        .mem0_fi_c_0 (mem0),
        .mem1_fi_c_0 (mem1),
        .tsqr_fi     (fi),
        .ug_i        (ug_i),
        .pg_i        (pg_i),
        .ug_ready    (ug_ready),
        .pg_ready    (pg_ready),
        .e_ug        (e_ug),
        .e_pg        (e_pg),
        .e_upg       (e_upg),
        .e_ug_ready  (e_ug_ready),
        .e_pg_ready  (e_pg_ready),
        .e_upg_ready (e_upg_ready),
        .busy        (busy),
        .tsqr_done   (tsqr_done),
        .start_err   (start_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [RW-1:0] obs,
                       input logic [RW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Upstream source: one row offered at a time, recorded when accepted.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (src_valid && src_ready) begin
                exp_q.push_back(cur);
                feed_left--;
                src_valid = 1'b0;
            end
            if (!src_valid && feed_left > 0) begin
                for (int w = 0; w < RW / 32; w++) begin
                    cur.ug[w*32 +: 32] = $urandom();
                    cur.pg[w*32 +: 32] = $urandom();
                end
                cur.eu    = $urandom();
                cur.ep    = $urandom();
                cur.eup   = $urandom();
                src_ug    = cur.ug;
                src_pg    = cur.pg;
                src_e_ug  = cur.eu;
                src_e_pg  = cur.ep;
                src_e_upg = cur.eup;
                src_valid = 1'b1;
            end
        end
    end

    // Core-side observer: rows must leave in arrival order, e_* on tile 0 only.
    initial forever begin
        row_t r;
        @(negedge clk);
        if (!rst) begin
            chk("pg_ready_eq", pg_ready, ug_ready);
            chk("e_pg_ready_eq", e_pg_ready, e_ug_ready);
            chk("e_upg_ready_eq", e_upg_ready, e_ug_ready);
            if (ug_ready) begin
                chk("row_available", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    r = exp_q.pop_front();
                    chk("ug_data", ug_i, r.ug);
                    chk("pg_data", pg_i, r.pg);
                    chk("e_ready_tile0", e_ug_ready, rows_out < MW);
                    if (rows_out < MW) begin
                        chk("e_ug_data", e_ug, r.eu);
                        chk("e_pg_data", e_pg, r.ep);
                        chk("e_upg_data", e_upg, r.eup);
                    end
                end
                row_cyc.push_back(cyc);
                rows_out++;
            end else begin
                chk("e_ready_idle", e_ug_ready, 0);
            end
        end
    end

    task automatic pulse_en(input logic [15:0] n);
        @(negedge clk);
        tsqr_en = 1'b1;
        tile_no = n;
        en_cyc  = cyc;
        @(negedge clk);
        tsqr_en = 1'b0;
    endtask

    task automatic start_job(input logic [15:0] n);
        rows_out = 0;
        row_cyc.delete();
        pulse_en(n);
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0: mem0 = 1'b1;
            1: mem1 = 1'b1;
            default: fi = 1'b1;
        endcase
        p_cyc = cyc;
        @(negedge clk);
        mem0 = 1'b0;
        mem1 = 1'b0;
        fi   = 1'b0;
    endtask

    task automatic wait_rows(input int n, input int budget, input string tag);
        int t = 0;
        while (rows_out < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(tag, rows_out, n);
    endtask

    task automatic finish_job(input string tag);
        pulse(2);
        chk({tag, "_done"}, tsqr_done, 1);
        chk({tag, "_busy_low"}, busy, 0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, tsqr_done, 0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_ug_ready", ug_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_done", tsqr_done, 0);
        chk("rst_start_err", start_err, 0);
        chk("rst_ug_i", ug_i, 0);
        rst = 1'b0;
        #1 chk("rel_src_ready_lag", src_ready, 0);
        @(negedge clk);
        chk("rel_src_ready", src_ready, 1);

        // Burst of three tiles, then a tile released by mem0.
        feed_left = 32;
        repeat (20) @(negedge clk);
        chk("t1_full_ready_low", src_ready, 0);
        chk("t1_idle_no_rows", ug_ready, 0);
        start_job(4);
        chk("t1_busy", busy, 1);
        wait_rows(24, 80, "t1_burst_rows");
        chk("t1_first_row", row_cyc[0], en_cyc + 2);
        chk("t1_burst_contig", row_cyc[23] - row_cyc[0], 23);
        repeat (5) @(negedge clk);
        chk("t1_hold_for_fi", rows_out, 24);
        chk("t1_busy_wait", busy, 1);
        pulse(0);
        wait_rows(32, 20, "t1_tile3_rows");
        chk("t1_tile3_start", row_cyc[24], p_cyc + 2);
        chk("t1_tile3_contig", row_cyc[31] - row_cyc[24], 7);
        repeat (3) @(negedge clk);
        finish_job("t1");

        // Zero-tile job.
        start_job(0);
        chk("t2_busy", busy, 1);
        chk("t2_no_done_yet", tsqr_done, 0);
        @(negedge clk);
        chk("t2_busy_low", busy, 0);
        chk("t2_done", tsqr_done, 1);
        @(negedge clk);
        chk("t2_done_1cyc", tsqr_done, 0);
        chk("t2_no_rows", rows_out, 0);

        // Two tiles end straight in the done wait.
        feed_left = 16;
        start_job(2);
        wait_rows(16, 60, "t3_rows");
        repeat (4) @(negedge clk);
        chk("t3_no_extra", rows_out, 16);
        chk("t3_busy", busy, 1);
        chk("t3_not_done", tsqr_done, 0);
        finish_job("t3");

        // Early mem0 finish, then a tile that must wait for mem1.
        feed_left = 40;
        start_job(5);
        repeat (2) @(negedge clk);
        pulse_en(1);
        chk("t4_start_err", start_err, 1);
        @(negedge clk);
        chk("t4_start_err_1cyc", start_err, 0);
        wait_rows(18, 60, "t4_mid_tile2");
        pulse(0);
        wait_rows(32, 60, "t4_tile3_rows");
        chk("t4_tile3_gap", row_cyc[24] - row_cyc[23], 2);
        repeat (5) @(negedge clk);
        chk("t4_wait_mem1", rows_out, 32);
        pulse(0);
        repeat (5) @(negedge clk);
        chk("t4_mem0_ignored", rows_out, 32);
        pulse(1);
        wait_rows(40, 20, "t4_tile4_rows");
        chk("t4_tile4_start", row_cyc[32], p_cyc + 2);
        finish_job("t4");

        // Source stalls partway into tile 1.
        feed_left = 13;
        start_job(2);
        wait_rows(8, 40, "t5_tile0_rows");
        repeat (10) @(negedge clk);
        chk("t5_stall_rows", rows_out, 8);
        chk("t5_stall_ready", ug_ready, 0);
        feed_left = feed_left + 3;
        wait_rows(16, 40, "t5_tile1_rows");
        chk("t5_tile1_contig", row_cyc[15] - row_cyc[8], 7);
        finish_job("t5");

        // Asynchronous abort mid-tile, then a clean job on fresh rows.
        feed_left = 24;
        start_job(3);
        wait_rows(4, 40, "t6_pre_rst");
        @(negedge clk);
        rst = 1'b1;
        feed_left = 0;
        src_valid = 1'b0;
        #1;
        chk("t6_rst_ug_ready", ug_ready, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_src_ready", src_ready, 0);
        chk("t6_rst_ug_i", ug_i, 0);
        chk("t6_rst_e_ug", e_ug, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_src_ready_back", src_ready, 1);
        feed_left = 8;
        start_job(1);
        wait_rows(8, 40, "t6_fresh_rows");
        finish_job("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
